// File: rtl/impix_system_switch_debouncer_pkg.sv
// Shared system constants for the switch conditioning path and the helper
// that turns a debounce time into a clk cycle count.
package impix_system_switch_debouncer_pkg;

  localparam int unsigned CLK_FREQ_HZ        = 50_000_000;
  localparam int unsigned SWITCH_DEBOUNCE_MS = 10;

  function automatic int unsigned ms_to_cycles(input int unsigned clk_hz,
                                               input int unsigned ms);
    return (clk_hz / 1000) * ms;
  endfunction

endpackage

// File: rtl/impix_system_switch_debouncer_debounce_bit.sv
// One switch bit: SYNC_STAGES-deep synchronizer followed by a mismatch
// counter that accepts a new level only after DEBOUNCE_CYCLES agreeing cycles.
module impix_system_debounce_bit #(
  parameter int   SYNC_STAGES     = 2,
  parameter int   DEBOUNCE_CYCLES = 500000,
  parameter logic RESET_BIT       = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic stable,
  output logic rise,
  output logic fall
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0]       cnt;
  logic                   sync;

  assign sync = sync_q[SYNC_STAGES-1];

  // Any cycle where sync agrees with stable wipes the count: no partial credit.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync_q <= {SYNC_STAGES{RESET_BIT}};
      stable <= RESET_BIT;
      cnt    <= '0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
      rise   <= 1'b0;
      fall   <= 1'b0;
      if (sync == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        stable <= sync;
        cnt    <= '0;
        rise   <= sync;
        fall   <= ~sync;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/impix_system_switch_debouncer.sv
// Debounces the board slide switches; sw_stable feeds the switches PIO and the
// strobes are available for edge capture.
module impix_system_switch_debouncer
  import impix_system_switch_debouncer_pkg::*;
#(
  parameter int               WIDTH           = 4,
  parameter int               SYNC_STAGES     = 2,
  parameter int               DEBOUNCE_CYCLES = int'(ms_to_cycles(CLK_FREQ_HZ, SWITCH_DEBOUNCE_MS)),
  parameter logic [WIDTH-1:0] RESET_VALUE     = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_stable,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic             sw_changed
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    impix_system_debounce_bit #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .RESET_BIT       (RESET_VALUE[i])
    ) u_bit (
      .clk     (clk),
      .reset_n (reset_n),
      .raw     (sw_raw[i]),
      .stable  (sw_stable[i]),
      .rise    (sw_rise[i]),
      .fall    (sw_fall[i])
    );
  end

  // Pure OR of strobe flops, so it pulses in the same cycle and only once
  // even when several bits accept together.
  assign sw_changed = |(sw_rise | sw_fall);

endmodule

// File: tb/tb_impix_system_switch_debouncer.sv
// Directed bench for the switch debouncer with DEBOUNCE_CYCLES=8, so each
// accepted change lands exactly 10 edges after the first sampling edge.
module tb_impix_system_switch_debouncer;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [W-1:0] sw_raw;
  logic [W-1:0] sw_stable, sw_rise, sw_fall;
  logic         sw_changed;

  int vectors = 0;
  int miscompares = 0;

  impix_system_switch_debouncer #(
    .WIDTH           (W),
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (8),
    .RESET_VALUE     (4'h0)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .sw_raw     (sw_raw),
    .sw_stable  (sw_stable),
    .sw_rise    (sw_rise),
    .sw_fall    (sw_fall),
    .sw_changed (sw_changed)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One rising edge, then sample 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [W-1:0] st,
                           input logic [W-1:0] ri, input logic [W-1:0] fa,
                           input logic ch);
    check({tag, "_stable"}, sw_stable, st);
    check({tag, "_rise"}, sw_rise, ri);
    check({tag, "_fall"}, sw_fall, fa);
    check({tag, "_changed"}, {3'b000, sw_changed}, {3'b000, ch});
  endtask

  task automatic quiet(input string tag, input int n, input logic [W-1:0] st);
    for (int k = 0; k < n; k++) begin
      step();
      check_all(tag, st, 4'h0, 4'h0, 1'b0);
    end
  endtask

  // Nine quiet edges, accept on the tenth, strobes gone on the eleventh.
  task automatic accept(input string tag, input logic [W-1:0] old_v,
                        input logic [W-1:0] new_v, input logic [W-1:0] ri,
                        input logic [W-1:0] fa);
    quiet({tag, "_wait"}, 9, old_v);
    step();
    check_all({tag, "_edge"}, new_v, ri, fa, 1'b1);
    step();
    check_all({tag, "_after"}, new_v, 4'h0, 4'h0, 1'b0);
  endtask

  initial begin
    // Reset hold with all switches already on
    reset_n = 1'b0;
    sw_raw  = 4'hF;
    quiet("rst_hold", 5, 4'h0);
    reset_n = 1'b1;
    accept("powerup", 4'h0, 4'hF, 4'hF, 4'h0);
    sw_raw = 4'h0;
    accept("all_off", 4'hF, 4'h0, 4'h0, 4'hF);

    // Clean step up and down on bit 0
    sw_raw = 4'h1;
    accept("clean_up", 4'h0, 4'h1, 4'h1, 4'h0);
    sw_raw = 4'h0;
    accept("clean_dn", 4'h1, 4'h0, 4'h0, 4'h1);

    // Bounce on bit 2: 5 high / 3 low, six times, then hold high
    for (int r = 0; r < 6; r++) begin
      sw_raw = 4'h4;
      quiet("bounce_hi", 5, 4'h0);
      sw_raw = 4'h0;
      quiet("bounce_lo", 3, 4'h0);
    end
    sw_raw = 4'h4;
    accept("bounce_hold", 4'h0, 4'h4, 4'h4, 4'h0);
    quiet("bounce_once", 6, 4'h4);
    sw_raw = 4'h0;
    accept("bounce_rel", 4'h4, 4'h0, 4'h0, 4'h4);

    // Glitch on bit 1: one cycle short of acceptance
    sw_raw = 4'h2;
    quiet("glitch_hi", 7, 4'h0);
    sw_raw = 4'h0;
    quiet("glitch_lo", 12, 4'h0);

    // Simultaneous changes
    sw_raw = 4'hA;
    accept("simul_a", 4'h0, 4'hA, 4'hA, 4'h0);
    sw_raw = 4'h5;
    accept("simul_5", 4'hA, 4'h5, 4'h5, 4'hA);
    sw_raw = 4'h0;
    accept("simul_0", 4'h5, 4'h0, 4'h0, 4'h5);

    // Reset mid-count on bit 3 (count reaches 5 after 7 edges)
    sw_raw = 4'h8;
    quiet("midrst_cnt", 7, 4'h0);
    reset_n = 1'b0;
    step();
    check_all("midrst_in", 4'h0, 4'h0, 4'h0, 1'b0);
    reset_n = 1'b1;
    accept("midrst_rel", 4'h0, 4'h8, 4'h8, 4'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
